// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/dispatch controller for the 16-bit CPU
//
// Sequences the program counter through pc_reset/pc_load/pc_inc strobes.
// Fetches instruction words over a mem_req/mem_ack handshake and hands
// each word to execute over an ir_valid/exec_ready handshake. Also owns
// branch and halt/resume flow.
//
// Optional feature macro: SEQ_IRQ_EN. When it is defined, the irq/irq_ack/epc
// ports are added and interrupts are taken on the dispatch handshake.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   pc_value         current PC
//   pc_reset/pc_load/pc_inc, pc_target   PC control strobes and load value
//   mem_req, mem_addr, mem_ack, mem_rdata instruction fetch handshake
//   ir_out, ir_valid, exec_ready         dispatch handshake to execute
//   branch_taken, branch_target, halt_req qualified by the dispatch handshake
//   resume           leave HALT
//   running          high in FETCH or DISPATCH
//   irq, irq_ack, epc                    interrupt (SEQ_IRQ_EN only)
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_value,
  output logic        pc_reset,
  output logic        pc_load,
  output logic        pc_inc,
  output logic [15:0] pc_target,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  input  logic        exec_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt_req,
  input  logic        resume,
`ifdef SEQ_IRQ_EN
  input  logic        irq,
  output logic        irq_ack,
  output logic [15:0] epc,
`endif
  output logic        running
);

  localparam logic [1:0] S_RST      = 2'd0;
  localparam logic [1:0] S_FETCH    = 2'd1;
  localparam logic [1:0] S_DISPATCH = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

`ifdef SEQ_IRQ_EN
  localparam logic [15:0] IRQ_VECTOR = 16'h0004;
  logic [15:0] epc_q;
`endif

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] ir_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:      state_nxt = S_FETCH;
      S_FETCH:    if (mem_ack) state_nxt = S_DISPATCH;
      S_DISPATCH: if (exec_ready) state_nxt = halt_req ? S_HALT : S_FETCH;
      S_HALT:     if (resume) state_nxt = S_FETCH;
      default:    state_nxt = S_RST;
    endcase
  end

  // Instruction register: captured once per fetch, cleared by reset
  always_ff @(posedge clk) begin
    if (reset)                         ir_q <= 16'h0000;
    else if (state == S_FETCH && mem_ack) ir_q <= mem_rdata;
  end

`ifdef SEQ_IRQ_EN
  // Return address is where the interrupted flow would have gone next
  always_ff @(posedge clk) begin
    if (reset)
      epc_q <= 16'h0000;
    else if (state == S_DISPATCH && exec_ready && irq)
      epc_q <= branch_taken ? branch_target : pc_value + 16'd1;
  end
`endif

  // Output logic. While reset is asserted the outputs already look like RST,
  // so the PC is being cleared even before the first edge lands state in RST.
  always_comb begin
    pc_reset  = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_target = 16'h0000;
    mem_req   = 1'b0;
    mem_addr  = 16'h0000;
    ir_valid  = 1'b0;
    running   = 1'b0;
    ir_out    = reset ? 16'h0000 : ir_q;
`ifdef SEQ_IRQ_EN
    irq_ack   = 1'b0;
    epc       = reset ? 16'h0000 : epc_q;
`endif
    if (reset) begin
      pc_reset = 1'b1;
    end else begin
      case (state)
        S_RST: pc_reset = 1'b1;
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc_value;
          running  = 1'b1;
        end
        S_DISPATCH: begin
          ir_valid = 1'b1;
          running  = 1'b1;
          // Exactly one PC strobe on the handshake; irq beats branch beats inc
          if (exec_ready) begin
`ifdef SEQ_IRQ_EN
            if (irq) begin
              pc_load   = 1'b1;
              pc_target = IRQ_VECTOR;
              irq_ack   = 1'b1;
            end else
`endif
            if (branch_taken) begin
              pc_load   = 1'b1;
              pc_target = branch_target;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_value;
  logic        pc_reset, pc_load, pc_inc;
  logic [15:0] pc_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        exec_ready, branch_taken;
  logic [15:0] branch_target;
  logic        halt_req, resume;
  logic        running;
`ifdef SEQ_IRQ_EN
  logic        irq;
  logic        irq_ack;
  logic [15:0] epc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .pc_value(pc_value),
    .pc_reset(pc_reset), .pc_load(pc_load), .pc_inc(pc_inc), .pc_target(pc_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_out(ir_out), .ir_valid(ir_valid), .exec_ready(exec_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .resume(resume),
`ifdef SEQ_IRQ_EN
    .irq(irq), .irq_ack(irq_ack), .epc(epc),
`endif
    .running(running)
  );

  // Program counter and instruction memory models
  logic [15:0] pc = 16'h1234;
  always @(posedge clk) begin
    if (pc_reset)     pc <= 16'h0000;
    else if (pc_load) pc <= pc_target;
    else if (pc_inc)  pc <= pc + 16'd1;
  end
  assign pc_value  = pc;
  assign mem_rdata = mem_addr + 16'h1000;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, ack, rdy, br;
    logic [15:0] bt;
    logic        hlt, res;
    logic        prst, pld, pinc;
    logic [15:0] ptgt;
    logic        mreq;
    logic [15:0] maddr;
    logic        irv;
    logic [15:0] ir;
    logic        run;
  } vec_t;

  localparam int S_RST = 0, S_FET = 1, S_DIS = 2, S_HLT = 3;
  localparam int NO = 0, INC = 1, LD = 2;

  // st is the hand-determined state for the row; val is fetch address or load target
  function automatic vec_t row(input logic rst, ack, rdy, br, input logic [15:0] bt,
                               input logic hlt, res, input int st,
                               input logic [15:0] val, input logic [15:0] ir, input int strobe);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdy = rdy; v.br = br; v.bt = bt; v.hlt = hlt; v.res = res;
    v.prst  = (st == S_RST);
    v.mreq  = (st == S_FET);
    v.maddr = (st == S_FET) ? val : 16'h0000;
    v.irv   = (st == S_DIS);
    v.run   = (st == S_FET) || (st == S_DIS);
    v.pinc  = (strobe == INC);
    v.pld   = (strobe == LD);
    v.ptgt  = (strobe == LD) ? val : 16'h0000;
    v.ir    = ir;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    reset = 1'b1; mem_ack = 1'b0; exec_ready = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0000; halt_req = 1'b0; resume = 1'b0;
`ifdef SEQ_IRQ_EN
    irq = 1'b0;
`endif

    // Reset, sequential run, halt at PC=3, resume
    tbl.push_back(row(1,0,0,0,16'h0,0,0, S_RST,16'h0,16'h0,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_RST,16'h0,16'h0,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_FET,16'h0,16'h0,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_DIS,16'h0,16'h1000,INC));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_FET,16'h1,16'h1000,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_DIS,16'h0,16'h1001,INC));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_FET,16'h2,16'h1001,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_DIS,16'h0,16'h1002,INC));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_FET,16'h3,16'h1002,NO));
    tbl.push_back(row(0,1,1,0,16'h0,1,0, S_DIS,16'h0,16'h1003,INC));
    for (int i = 0; i < 10; i++)
      tbl.push_back(row(0,1,1,1,16'h55,1,0, S_HLT,16'h0,16'h1003,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,1, S_HLT,16'h0,16'h1003,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_FET,16'h4,16'h1003,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_DIS,16'h0,16'h1004,INC));
    // Memory wait at PC=5 (stray exec/branch/halt inputs ignored), then dispatch stall
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(0,0,1,1,16'h77,1,0, S_FET,16'h5,16'h1004,NO));
    tbl.push_back(row(0,1,0,0,16'h0,0,0, S_FET,16'h5,16'h1004,NO));
    tbl.push_back(row(0,1,0,0,16'h0,0,0, S_DIS,16'h0,16'h1005,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_DIS,16'h0,16'h1005,INC));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_FET,16'h6,16'h1005,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_DIS,16'h0,16'h1006,INC));
    // Branch at PC=7 to 0x0040
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_FET,16'h7,16'h1006,NO));
    tbl.push_back(row(0,1,1,1,16'h40,0,0, S_DIS,16'h40,16'h1007,LD));
    tbl.push_back(row(0,1,0,0,16'h0,0,0, S_FET,16'h40,16'h1007,NO));
    // Reset mid-DISPATCH with exec_ready low
    tbl.push_back(row(0,1,0,0,16'h0,0,0, S_DIS,16'h0,16'h1040,NO));
    tbl.push_back(row(1,1,0,0,16'h0,0,0, S_RST,16'h0,16'h0,NO));
    tbl.push_back(row(0,1,1,0,16'h0,0,0, S_RST,16'h0,16'h0,NO));
    tbl.push_back(row(0,0,0,0,16'h0,0,0, S_FET,16'h0,16'h0,NO));

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; mem_ack = tbl[i].ack; exec_ready = tbl[i].rdy;
      branch_taken = tbl[i].br; branch_target = tbl[i].bt;
      halt_req = tbl[i].hlt; resume = tbl[i].res;
      #1;
      chk($sformatf("r%0d pc_reset", i),  {15'd0, pc_reset}, {15'd0, tbl[i].prst});
      chk($sformatf("r%0d pc_load", i),   {15'd0, pc_load},  {15'd0, tbl[i].pld});
      chk($sformatf("r%0d pc_inc", i),    {15'd0, pc_inc},   {15'd0, tbl[i].pinc});
      chk($sformatf("r%0d pc_target", i), pc_target,         tbl[i].ptgt);
      chk($sformatf("r%0d mem_req", i),   {15'd0, mem_req},  {15'd0, tbl[i].mreq});
      chk($sformatf("r%0d mem_addr", i),  mem_addr,          tbl[i].maddr);
      chk($sformatf("r%0d ir_valid", i),  {15'd0, ir_valid}, {15'd0, tbl[i].irv});
      chk($sformatf("r%0d ir_out", i),    ir_out,            tbl[i].ir);
      chk($sformatf("r%0d running", i),   {15'd0, running},  {15'd0, tbl[i].run});
      chk($sformatf("r%0d strobes<=1", i),
          16'(int'(pc_reset) + int'(pc_load) + int'(pc_inc)) <= 16'd1 ? 16'd1 : 16'd0, 16'd1);
    end

    // Reset during a FETCH wait: request drops immediately, then refetch at 0
    begin
      bit found = 1'b0;
      @(negedge clk); reset = 1'b1; mem_ack = 1'b0; exec_ready = 1'b0; #1;
      chk("rstfetch mem_req", {15'd0, mem_req}, 16'd0);
      chk("rstfetch pc_reset", {15'd0, pc_reset}, 16'd1);
      @(negedge clk); reset = 1'b0; #1;
      chk("rstfetch rst pc_reset", {15'd0, pc_reset}, 16'd1);
      chk("rstfetch rst mem_req", {15'd0, mem_req}, 16'd0);
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        if (mem_req) begin found = 1'b1; break; end
      end
      chk("refetch seen", {15'd0, found}, 16'd1);
      chk("refetch addr", mem_addr, 16'h0000);
    end

    // Halt, then reset together with resume: reset wins
    @(negedge clk); exec_ready = 1'b1; halt_req = 1'b1; mem_ack = 1'b0; #1;
    chk("halt2 pc_inc", {15'd0, pc_inc}, 16'd1);
    @(negedge clk); exec_ready = 1'b0; halt_req = 1'b0; #1;
    chk("halt2 running", {15'd0, running}, 16'd0);
    chk("halt2 mem_req", {15'd0, mem_req}, 16'd0);
    @(negedge clk); reset = 1'b1; resume = 1'b1; #1;
    chk("rst+resume pc_reset", {15'd0, pc_reset}, 16'd1);
    @(negedge clk); reset = 1'b0; resume = 1'b0; #1;
    chk("rst+resume in RST", {15'd0, pc_reset}, 16'd1);
    chk("rst+resume running", {15'd0, running}, 16'd0);

`ifdef SEQ_IRQ_EN
    // Interrupt together with branch at PC=9
    begin
      bit found = 1'b0;
      chk("epc reset", epc, 16'h0000);
      mem_ack = 1'b1; exec_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); irq = 1'b0; branch_taken = 1'b0; #1;
        if (ir_valid && pc_value == 16'd9) begin found = 1'b1; break; end
      end
      chk("irq reach pc9", {15'd0, found}, 16'd1);
      irq = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040; #1;
      chk("irq pc_load", {15'd0, pc_load}, 16'd1);
      chk("irq pc_inc", {15'd0, pc_inc}, 16'd0);
      chk("irq pc_target", pc_target, 16'h0004);
      chk("irq irq_ack", {15'd0, irq_ack}, 16'd1);
      @(negedge clk); irq = 1'b0; branch_taken = 1'b0; #1;
      chk("irq ack drop", {15'd0, irq_ack}, 16'd0);
      chk("irq epc", epc, 16'h0040);
      chk("irq vector fetch", mem_addr, 16'h0004);
      @(negedge clk); #1;
      chk("no irq pc_inc", {15'd0, pc_inc}, 16'd1);
      chk("no irq ack", {15'd0, irq_ack}, 16'd0);
      @(negedge clk); #1;
      chk("epc unchanged", epc, 16'h0040);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch/dispatch controller for the 16-bit CPU. It sequences the program counter by driving its reset, load and increment strobes, and fetches instruction words from memory over a req/ack handshake. Each captured word is handed to the decode/execute stage over a valid/ready handshake. The sequencer sits between the program counter, instruction memory and the execute stage, and owns all program-flow control: sequential fetch, taken branches, halt/resume and an optional interrupt.

## Interface
- IRQ_VECTOR, 16'h0004, PC value loaded on interrupt entry (used only with SEQ_IRQ_EN).
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- pc_value  input  16  current program counter output.
- pc_reset  output  1  strobe: clear PC.
- pc_load  output  1  strobe: load PC from pc_target.
- pc_inc  output  1  strobe: PC <= PC + 1.
- pc_target  output  16  load value for PC.
- mem_req  output  1  fetch request.
- mem_addr  output  16  fetch address (= pc_value).
- mem_ack  input  1  read data valid this cycle.
- mem_rdata  input  16  instruction word.
- ir_out  output  16  registered instruction word.
- ir_valid  output  1  ir_out valid for execute.
- exec_ready  input  1  execute accepts ir_out this cycle.
- branch_taken  input  1  qualified by ir_valid & exec_ready.
- branch_target  input  16  new PC when branch_taken.
- halt_req  input  1  qualified by ir_valid & exec_ready.
- resume  input  1  leave HALT.
- running  output  1  high in FETCH or DISPATCH.
- irq, irq_ack, epc  input 1 / output 1 / output 16  (present only with SEQ_IRQ_EN).

## Operation
- States: RST, FETCH, DISPATCH, HALT. Reset forces RST.
- RST: pc_reset=1 for exactly one cycle, then go to FETCH.
- FETCH: mem_req=1 and mem_addr=pc_value, held stable until mem_ack. On mem_ack, ir_out<=mem_rdata, ir_valid<=1, go to DISPATCH.
- DISPATCH: ir_valid=1 and ir_out held until exec_ready. The handshake cycle (ir_valid & exec_ready) issues exactly one PC strobe, chosen by priority:
  - irq (IRQ_EN): pc_load with pc_target=IRQ_VECTOR.
  - branch_taken: pc_load with pc_target=branch_target.
  - otherwise: pc_inc.
- After the handshake: ir_valid<=0; next state is HALT if halt_req, else FETCH. A halted instruction's PC update still occurs.
- HALT: no strobes, mem_req=0. Stay until resume=1, then go to FETCH.
- pc_load and pc_inc are never asserted together. At most one strobe is asserted in any cycle.
- pc_target=0 whenever pc_load=0.
- Outputs in RST/HALT: mem_req=0, ir_valid=0, running=0.

## Timing
- During reset and the cycle after: all outputs 0 except pc_reset=1. Also ir_out=0 and epc=0.
- Strobes are combinational from state and inputs. PC updates on the same edge the FSM leaves DISPATCH, so FETCH sees the new pc_value.
- Minimum throughput: 2 cycles/instruction (mem_ack in the first FETCH cycle, exec_ready in the first DISPATCH cycle).
- Each FETCH wait cycle and each DISPATCH stall cycle adds 1 cycle.
- Wrap-around is owned by the PC: 16'hFFFF + inc gives 0. The sequencer applies no check.
- mem_ack outside FETCH is ignored. exec_ready, branch_taken and halt_req outside DISPATCH are ignored.
- Reset mid-FETCH or mid-DISPATCH: next cycle is RST, with mem_req=0 and ir_valid=0 immediately after the edge. The in-flight instruction is discarded.
- resume together with reset: reset wins.

## Configuration
- SEQ_IRQ_EN defined:
  - irq is sampled only on the DISPATCH handshake cycle and has priority over branch_taken.
  - On that cycle: epc<=(branch_taken ? branch_target : pc_value+1) and irq_ack=1 for that single cycle.
  - halt_req is still honoured after interrupt entry.
- SEQ_IRQ_EN undefined: the irq, irq_ack and epc ports are absent, IRQ_VECTOR is unused, and there is no interrupt logic.

## Test plan
- Reset then sequential run: mem_ack and exec_ready tied 1, memory returns addr+16'h1000. Required: pc_reset pulse; ir_out 16'h1000, 16'h1001, 16'h1002 every 2 cycles; one pc_inc per instruction.
- Memory wait: mem_ack delayed 3 cycles at PC=5. Required: mem_req and mem_addr=5 held stable for 4 cycles; single capture; no strobe during the wait.
- Branch: branch_taken=1, branch_target=16'h0040 on a handshake at PC=7. Required: pc_load=1, pc_target=16'h0040, pc_inc=0; next mem_addr=16'h0040.
- Halt/resume: halt_req at PC=3. Required: pc_inc, then HALT with running=0 and no mem_req for 10 cycles; resume gives fetch at 4.
- Reset mid-DISPATCH with exec_ready=0. Required: ir_valid=0 after the edge, pc_reset asserted, then fetch at 0.
- With SEQ_IRQ_EN: irq together with branch_taken (target 16'h0040) at PC=9. Required: pc_target=16'h0004, epc=16'h0040, irq_ack for one cycle. Without irq at PC=9: epc unchanged.
